// File: rtl/fraction_multiplication_pkg.sv
// Shared widths, FSM state type and saturation value for the Q0.3 x Q0.3 fraction multiplier.
package fraction_multiplication_pkg;

  localparam int OPW = 4;
  localparam int PW  = 7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  localparam logic [PW-1:0] PROD_MAX = 7'h3F;

endpackage

// File: rtl/fraction_multiplication_addsub.sv
// Accumulator update: adds the sign-extended multiplicand, or subtracts it on the sign-bit step.
module frac_addsub
  import fraction_multiplication_pkg::*;
(
  input  logic [OPW:0]   a_i,
  input  logic [OPW-1:0] c_i,
  input  logic           is_last_i,
  output logic [OPW:0]   sum_o
);

  logic [OPW:0] c_ext;

  assign c_ext = {c_i[OPW-1], c_i};
  assign sum_o = is_last_i ? (a_i - c_ext) : (a_i + c_ext);

endmodule

// File: rtl/fraction_multiplication.sv
// Sequential add-and-shift two's-complement fraction multiplier, Q0.3 x Q0.3 -> Q0.6.
// state | meaning
// IDLE  | waiting for St, operands captured on the start edge
// CALC  | four add/shift steps, last one subtracts for the sign-bit weight
module fraction_multiplication
  import fraction_multiplication_pkg::*;
(
  input  logic           CLK,
  input  logic           St,
  input  logic [OPW-1:0] Mplier,
  input  logic [OPW-1:0] Mcand,
  output logic [PW-1:0]  Product,
  output logic           Done,
  input  logic           RSTN
);

  state_e         state_q;
  logic [OPW:0]   a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [OPW-1:0] c_q;
  logic [1:0]     cnt_q;
  logic [PW-1:0]  product_q;
  logic           done_q;

  logic           is_last;
  logic [OPW:0]   sum;
  logic [OPW:0]   acc;
  logic [7:0]     prod_full;
  logic [PW-1:0]  prod_sat;

  assign is_last = (cnt_q == 2'd3);

  frac_addsub u_addsub (
    .a_i       (a_q),
    .c_i       (c_q),
    .is_last_i (is_last),
    .sum_o     (sum)
  );

  always_comb begin
    acc       = b_q[0] ? sum : a_q;
    a_d       = {acc[OPW], acc[OPW:1]};
    b_d       = {acc[0], b_q[OPW-1:1]};
    // {A[3:0],B} after the final shift is exactly {acc, B[3:1]}
    prod_full = {acc, b_q[OPW-1:1]};
    // Only -1 x -1 reaches +1.0, visible as bit 7 disagreeing with bit 6
    prod_sat  = (prod_full[7] != prod_full[6]) ? PROD_MAX : prod_full[PW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (St) begin
            a_q     <= '0;
            b_q     <= Mplier;
            c_q     <= Mcand;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + 2'd1;
          if (is_last) begin
            product_q <= prod_sat;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign Product = product_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_fraction_multiplication.sv
// Directed and exhaustive checks for the sequential fraction multiplier.
module tb_fraction_multiplication;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       St = 1'b0;
  logic [3:0] Mplier = '0;
  logic [3:0] Mcand = '0;
  logic [6:0] Product;
  logic       Done;

  int n_checks = 0;
  int n_errors = 0;

  fraction_multiplication dut (
    .CLK    (CLK),
    .St     (St),
    .Mplier (Mplier),
    .Mcand  (Mcand),
    .Product(Product),
    .Done   (Done),
    .RSTN   (RSTN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
    int sa, sb, p;
    logic [31:0] pv;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    if (p == 64) return 7'h3F;
    pv = p;
    return pv[6:0];
  endfunction

  // Starts one multiply, scrambles inputs after the start edge, checks latency, result and pulse width
  task automatic mult(input string tag, input logic [3:0] mp, input logic [3:0] mc,
                      input logic [6:0] exp);
    int n;
    @(negedge CLK);
    St = 1'b1; Mplier = mp; Mcand = mc;
    @(posedge CLK); #1;
    St = 1'b0; Mplier = 4'($urandom); Mcand = 4'($urandom);
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check({tag, "_lat"}, n, 4);
    check({tag, "_prod"}, Product, exp);
    @(posedge CLK); #1;
    check({tag, "_done_w"}, Done, 0);
  endtask

  typedef struct {
    string      tag;
    logic [3:0] mp;
    logic [3:0] mc;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cnt, d1, d2;

    // Reset with St asserted: nothing may start
    St = 1'b1; Mplier = 4'h4; Mcand = 4'h4; RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_prod", Product, 0);
    check("rst_done", Done, 0);
    @(negedge CLK);
    St = 1'b0; RSTN = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (Done) cnt++;
    end
    check("rst_no_start", cnt, 0);
    check("rst_prod_hold", Product, 0);

    vecs.push_back('{"ff", 4'hF, 4'hF, 7'h01});
    vecs.push_back('{"00", 4'h0, 4'h0, 7'h00});
    vecs.push_back('{"01", 4'h0, 4'h1, 7'h00});
    vecs.push_back('{"44", 4'h4, 4'h4, 7'h10});
    vecs.push_back('{"95", 4'h9, 4'h5, 7'h5D});
    vecs.push_back('{"b1", 4'hB, 4'h1, 7'h7B});
    vecs.push_back('{"0a", 4'h0, 4'hA, 7'h00});
    vecs.push_back('{"88", 4'h8, 4'h8, 7'h3F});
    vecs.push_back('{"87", 4'h8, 4'h7, 7'h48});
    foreach (vecs[i]) mult(vecs[i].tag, vecs[i].mp, vecs[i].mc, vecs[i].exp);

    // St pulsed mid-calculation is ignored
    @(negedge CLK);
    St = 1'b1; Mplier = 4'h9; Mcand = 4'h5;
    @(posedge CLK); #1;
    St = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin St = 1'b1; Mplier = 4'h7; Mcand = 4'h7; end
      if (i == 2) St = 1'b0;
      @(posedge CLK); #1;
      if (Done) cnt++;
    end
    check("calc_st_dones", cnt, 1);
    check("calc_st_prod", Product, 7'h5D);

    // Reset during CALC aborts the operation and clears Product
    mult("pre_abort", 4'h4, 4'h4, 7'h10);
    @(negedge CLK);
    St = 1'b1; Mplier = 4'h3; Mcand = 4'h3;
    @(posedge CLK); #1;
    St = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b0;
    @(posedge CLK); #1;
    check("abort_prod", Product, 0);
    check("abort_done", Done, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (Done) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // St held high restarts every 5 cycles
    @(negedge CLK);
    St = 1'b1; Mplier = 4'h4; Mcand = 4'h2;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      if (Done && d1 < 0) d1 = i;
      else if (Done && d2 < 0) d2 = i;
    end
    St = 1'b0;
    check("hold_first", d1, 4);
    check("hold_period", d2 - d1, 5);
    check("hold_prod", Product, 7'h08);
    repeat (8) @(posedge CLK);
    #1;

    // Exhaustive sweep against the arithmetic reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mult($sformatf("ex_%0h_%0h", a, b), 4'(a), 4'(b), ref_prod(4'(a), 4'(b)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
